// File: rtl/bcd_to_bin_arbiter.sv
// Round-robin arbiter sharing one serial BCD-to-binary converter core among N_REQ requesters.
// Optional RANGE_CHECK_EN: reject operands with a digit >9 without starting the core (rsp_err=1).

module bcd_to_bin_core #(
  parameter int BCD_DIGITS = 4,
  parameter int BIN_W      = 14
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic                    start,
  input  logic [BCD_DIGITS*4-1:0] bcd_in,
  output logic                    rdy,
  output logic                    done,
  output logic [BIN_W-1:0]        bin_out
);
  localparam int DW = BCD_DIGITS * 4;
  localparam int CW = $clog2(BIN_W + 1);

  logic [DW-1:0]    bcd_r;
  logic [BIN_W-1:0] bin_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic             done_r;

  // Reverse double-dabble correction: any digit >= 8 after a right shift loses 3.
  function automatic logic [DW-1:0] fix_digits(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      if (v[d*4 +: 4] >= 4'd8) begin
        r[d*4 +: 4] = v[d*4 +: 4] - 4'd3;
      end else begin
        r[d*4 +: 4] = v[d*4 +: 4];
      end
    end
    return r;
  endfunction

  // One shift per cycle for BIN_W cycles, then a one-cycle done pulse.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bcd_r  <= '0;
      bin_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (busy_r) begin
        bcd_r <= fix_digits({1'b0, bcd_r[DW-1:1]});
        bin_r <= {bcd_r[0], bin_r[BIN_W-1:1]};
        if (cnt_r == CW'(BIN_W - 1)) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          cnt_r  <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else if (start) begin
        bcd_r  <= bcd_in;
        bin_r  <= '0;
        cnt_r  <= '0;
        busy_r <= 1'b1;
      end else begin
        busy_r <= 1'b0;
      end
    end
  end

  assign rdy     = ~busy_r;
  assign done    = done_r;
  assign bin_out = bin_r;
endmodule

module bcd_to_bin_arbiter_chk #(
  parameter int N_REQ = 4
) (
  input logic             clk,
  input logic             arst_n,
  input logic             start,
  input logic             rdy,
  input logic [N_REQ-1:0] req_ready
);
  a_start_rdy: assert property (@(posedge clk) disable iff (!arst_n) start |-> rdy);
  a_ready_onehot: assert property (@(posedge clk) disable iff (!arst_n) $onehot0(req_ready));
endmodule

module bcd_to_bin_arbiter #(
  parameter int N_REQ      = 4,
  parameter int BCD_DIGITS = 4,
  localparam int BIN_W     = $clog2(10**BCD_DIGITS),
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*BCD_DIGITS*4-1:0] req_bcd,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [BIN_W-1:0]              rsp_bin,
  output logic                          rsp_err
);
  localparam int DW = BCD_DIGITS * 4;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  state_t           state_r;
  logic [ID_W-1:0]  rr_ptr_r;
  logic [ID_W-1:0]  id_r;
  logic [ID_W-1:0]  grant_s;
  logic             grant_vld_s;
  logic [ID_W-1:0]  next_ptr_s;
  logic [DW-1:0]    sel_bcd_s;
  logic             hs_s;
  logic             core_start_s;
  logic             core_rdy_s;
  logic             core_done_s;
  logic [BIN_W-1:0] core_bin_s;

  // Cyclic search for the first valid requester at or after rr_ptr.
  always_comb begin
    grant_s     = '0;
    grant_vld_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!grant_vld_s && req_valid[(int'(rr_ptr_r) + i) % N_REQ]) begin
        grant_vld_s = 1'b1;
        grant_s     = ID_W'((int'(rr_ptr_r) + i) % N_REQ);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  assign next_ptr_s = (grant_s == ID_W'(N_REQ - 1)) ? '0 : grant_s + ID_W'(1);
  assign sel_bcd_s  = req_bcd[int'(grant_s)*DW +: DW];
  assign hs_s       = (state_r == ST_IDLE) && grant_vld_s && core_rdy_s;
  assign req_ready  = hs_s ? (N_REQ'(1) << grant_s) : '0;

`ifdef RANGE_CHECK_EN
  logic bad_s;

  function automatic logic any_bad_digit(input logic [DW-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      bad = bad | (v[d*4 +: 4] > 4'd9);
    end
    return bad;
  endfunction

  assign bad_s        = any_bad_digit(sel_bcd_s);
  assign core_start_s = hs_s & ~bad_s;
`else
  assign core_start_s = hs_s;
  assign rsp_err      = 1'b0;
`endif

  // Arbiter FSM; response fields only change on entry to RESP.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r   <= ST_IDLE;
      rr_ptr_r  <= '0;
      id_r      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_bin   <= '0;
`ifdef RANGE_CHECK_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            rr_ptr_r <= next_ptr_s;
            id_r     <= grant_s;
`ifdef RANGE_CHECK_EN
            if (bad_s) begin
              state_r   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_id    <= grant_s;
              rsp_bin   <= '0;
              rsp_err   <= 1'b1;
            end else begin
              state_r <= ST_BUSY;
            end
`else
            state_r <= ST_BUSY;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (core_done_s) begin
            state_r   <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_id    <= id_r;
            rsp_bin   <= core_bin_s;
`ifdef RANGE_CHECK_EN
            rsp_err   <= 1'b0;
`endif
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_r   <= ST_IDLE;
            rsp_valid <= 1'b0;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  bcd_to_bin_core #(
    .BCD_DIGITS (BCD_DIGITS),
    .BIN_W      (BIN_W)
  ) u_core (
    .clk     (clk),
    .arst_n  (arst_n),
    .start   (core_start_s),
    .bcd_in  (sel_bcd_s),
    .rdy     (core_rdy_s),
    .done    (core_done_s),
    .bin_out (core_bin_s)
  );

  bcd_to_bin_arbiter_chk #(
    .N_REQ (N_REQ)
  ) u_chk (
    .clk       (clk),
    .arst_n    (arst_n),
    .start     (core_start_s),
    .rdy       (core_rdy_s),
    .req_ready (req_ready)
  );
endmodule

// File: tb/tb_bcd_to_bin_arbiter.sv
// Randomized self-checking bench for bcd_to_bin_arbiter against an arithmetic reference model.
// Honours RANGE_CHECK_EN when the same macro is defined for the build.

module tb_bcd_to_bin_arbiter;
  localparam int N_REQ      = 4;
  localparam int BCD_DIGITS = 4;
  localparam int DW         = BCD_DIGITS * 4;
  localparam int BIN_W      = $clog2(10**BCD_DIGITS);
  localparam int ID_W       = $clog2(N_REQ);
`ifdef RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 arst_n;
  logic [N_REQ-1:0]     req_valid;
  logic [N_REQ*DW-1:0]  req_bcd;
  logic [N_REQ-1:0]     req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [BIN_W-1:0]     rsp_bin;
  logic                 rsp_err;
  logic [DW-1:0]        bcd_arr [N_REQ];

  int n_chk = 0;
  int n_err = 0;
  int rr    = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_bcd = '0;
    for (int i = 0; i < N_REQ; i++) req_bcd[i*DW +: DW] = bcd_arr[i];
  end

  bcd_to_bin_arbiter #(.N_REQ(N_REQ), .BCD_DIGITS(BCD_DIGITS)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .req_valid (req_valid),
    .req_bcd   (req_bcd),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_bin   (rsp_bin),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int bcd_val(input logic [DW-1:0] b);
    int v = 0;
    for (int d = BCD_DIGITS - 1; d >= 0; d--) v = v * 10 + int'(b[d*4 +: 4]);
    return v;
  endfunction

  function automatic bit has_bad(input logic [DW-1:0] b);
    bit bad = 1'b0;
    for (int d = 0; d < BCD_DIGITS; d++) if (b[d*4 +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [DW-1:0] rand_bcd(input bit allow_bad);
    logic [DW-1:0] b;
    int pos;
    for (int d = 0; d < BCD_DIGITS; d++) b[d*4 +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && $urandom_range(0, 3) == 0) begin
      pos = int'($urandom_range(0, BCD_DIGITS - 1));
      b[pos*4 +: 4] = 4'($urandom_range(10, 15));
    end
    return b;
  endfunction

  task automatic apply_reset();
    arst_n    = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_bin",   32'(rsp_bin),   32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    arst_n = 1'b1;
    rr     = 0;
    @(posedge clk);
    #1;
  endtask

  // One arbitration round: grant, conversion, optional back-pressure, response handshake.
  task automatic xact(input logic [N_REQ-1:0] mask, input int hold);
    int g;
    int lat;
    int exp_lat;
    bit bad;
    logic [31:0] exp_bin;
    req_valid = mask;
    #1;
    g = -1;
    for (int k = 0; k < N_REQ; k++) begin
      if (g < 0 && mask[(rr + k) % N_REQ]) g = (rr + k) % N_REQ;
    end
    if (g < 0) begin
      chk("idle_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      return;
    end
    chk("grant", 32'(req_ready), 32'd1 << g);
    bad     = has_bad(bcd_arr[g]);
    exp_lat = (RC && bad) ? 1 : BIN_W + 2;
    exp_bin = (RC && bad) ? 32'd0 : 32'(bcd_val(bcd_arr[g]));
    rr      = (g + 1) % N_REQ;
    @(posedge clk);
    #1;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      chk("busy_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("rsp_id", 32'(rsp_id), 32'(g));
    if (!bad || RC) chk("rsp_bin", 32'(rsp_bin), exp_bin);
    chk("rsp_err", 32'(rsp_err), 32'(RC && bad));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_id", 32'(rsp_id), 32'(g));
      if (!bad || RC) chk("hold_bin", 32'(rsp_bin), exp_bin);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = '0;
    chk("rsp_drop", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    int seen;
    arst_n    = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < N_REQ; i++) bcd_arr[i] = '0;
    apply_reset();

    bcd_arr[0] = 16'h9999;
    xact(4'b0001, 0);

    apply_reset();
    bcd_arr[0] = 16'h0000;
    bcd_arr[1] = 16'h0001;
    bcd_arr[2] = 16'h1234;
    bcd_arr[3] = 16'h0500;
    repeat (4) xact(4'b1111, 0);

    repeat (4) xact(4'b0101, 0);

    bcd_arr[2] = 16'h0777;
    xact(4'b0100, 20);

    // Reset while the core is busy must drop the request silently.
    bcd_arr[0] = 16'h4321;
    req_valid  = 4'b0001;
    #1;
    chk("midrst_grant", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (5) @(posedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_id",    32'(rsp_id),    32'd0);
    chk("midrst_bin",   32'(rsp_bin),   32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    arst_n = 1'b1;
    rr     = 0;
    seen   = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen++;
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    bcd_arr[0] = 16'h0042;
    xact(4'b0001, 0);

    bcd_arr[1] = 16'h12A4;
    xact(4'b0010, 0);

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < N_REQ; i++) bcd_arr[i] = rand_bcd(RC);
      xact(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
